// File: rtl/gate_truth_table_checker.sv
// Exhaustive self-checking sequencer for one N_IN-input combinational gate.
// Walks every input vector, samples the gate after SETTLE cycles and records mismatches against TRUTH.
module gate_truth_table_checker #(
  parameter int                      N_IN   = 2,
  parameter int                      SETTLE = 2,
  parameter logic [(2**N_IN)-1:0]    TRUTH  = 4'b0111
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       dut_y,
  output logic [N_IN-1:0]            dut_in,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [(2**N_IN)-1:0]       fail_vec,
  output logic [N_IN:0]              err_count
);

  localparam int V  = 2**N_IN;
  localparam int EW = N_IN + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   WAIT_LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_IDX  = N_IN'(V - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  state_t          r_state, w_stateNext;
  logic [N_IN-1:0] r_idx, w_idxNext, w_idxInc;
  logic [N_IN-1:0] r_dutIn, w_dutInNext;
  logic [CW-1:0]   r_waitCnt, w_waitCntNext;
  logic            r_busy, w_busyNext;
  logic            r_done, w_doneNext;
  logic            r_pass, w_passNext;
  logic [V-1:0]    r_failVec, w_failVecNext, w_failSampled;
  logic [EW-1:0]   r_errCount, w_errCountNext, w_errSampled;
  logic            w_mismatch;

  // Sample results are only consumed in SAMPLE, so an unknown dut_y elsewhere never reaches state.
  assign w_idxInc      = r_idx + N_IN'(1);
  assign w_mismatch    = (dut_y != TRUTH[r_idx]);
  assign w_failSampled = w_mismatch ? (r_failVec | (V'(1) << r_idx)) : r_failVec;
  assign w_errSampled  = r_errCount + EW'(w_mismatch);

  always_comb begin
    w_stateNext    = r_state;
    w_idxNext      = r_idx;
    w_dutInNext    = r_dutIn;
    w_waitCntNext  = r_waitCnt;
    w_busyNext     = r_busy;
    w_doneNext     = 1'b0;
    w_passNext     = r_pass;
    w_failVecNext  = r_failVec;
    w_errCountNext = r_errCount;

    case (r_state)
      IDLE, DONE: begin
        if (start && !abort) begin
          w_idxNext      = '0;
          w_dutInNext    = '0;
          w_failVecNext  = '0;
          w_errCountNext = '0;
          w_passNext     = 1'b0;
          w_waitCntNext  = WAIT_LOAD;
          w_busyNext     = 1'b1;
          w_stateNext    = WAIT;
        end else if (r_state == DONE) begin
          w_stateNext = IDLE;
        end
      end

      WAIT: begin
        if (abort) begin
          w_stateNext = IDLE;
          w_busyNext  = 1'b0;
          w_dutInNext = '0;
          w_idxNext   = '0;
          w_passNext  = 1'b0;
        end else if (r_waitCnt != '0) begin
          w_waitCntNext = r_waitCnt - CW'(1);
        end else begin
          w_stateNext = SAMPLE;
        end
      end

      SAMPLE: begin
        if (abort) begin
          w_stateNext = IDLE;
          w_busyNext  = 1'b0;
          w_dutInNext = '0;
          w_idxNext   = '0;
          w_passNext  = 1'b0;
        end else begin
          w_failVecNext  = w_failSampled;
          w_errCountNext = w_errSampled;
          // pass must reflect the final vector too, so it uses the freshly merged fail mask
          if (r_idx == LAST_IDX) begin
            w_stateNext = DONE;
            w_busyNext  = 1'b0;
            w_doneNext  = 1'b1;
            w_passNext  = (w_failSampled == '0);
          end else begin
            w_idxNext     = w_idxInc;
            w_dutInNext   = w_idxInc;
            w_waitCntNext = WAIT_LOAD;
            w_stateNext   = WAIT;
          end
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_busyNext  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_dutIn    <= '0;
      r_waitCnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_failVec  <= '0;
      r_errCount <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_idx      <= w_idxNext;
      r_dutIn    <= w_dutInNext;
      r_waitCnt  <= w_waitCntNext;
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
      r_pass     <= w_passNext;
      r_failVec  <= w_failVecNext;
      r_errCount <= w_errCountNext;
    end
  end

  assign dut_in    = r_dutIn;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_vec  = r_failVec;
  assign err_count = r_errCount;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: a behavioural gate model feeds dut_y, and run results
// are checked from a queue of expected {fail_vec, err_count, pass} records.
module tb_gate_truth_table_checker;

  localparam int NAND_G  = 0;
  localparam int AND_G   = 1;
  localparam int STUCK_1 = 2;

  typedef struct {
    int mode;
    int expFail;
    int expErr;
    int expPass;
    int restart;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dut_y;
  logic [1:0] dut_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic [2:0] err_count;

  int   mode = NAND_G;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[4];
  vec_t expQ[$];

  gate_truth_table_checker #(.N_IN(2), .SETTLE(2), .TRUTH(4'b0111)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(dut_y),
    .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
    .fail_vec(fail_vec), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Gate under test: a good NAND, an AND substituted by mistake, or a NAND stuck at 1.
  always_comb begin
    dut_y = 1'b1;
    case (mode)
      NAND_G: dut_y = ~(dut_in[1] & dut_in[0]);
      AND_G:  dut_y = dut_in[1] & dut_in[0];
      default: dut_y = 1'b1;
    endcase
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
  endtask

  // Each done pulse consumes one expected result record.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
      end else begin
        vec_t e;
        e = expQ.pop_front();
        checkOutput("sb_fail_vec", int'(fail_vec), e.expFail);
        checkOutput("sb_err_count", int'(err_count), e.expErr);
        checkOutput("sb_pass", int'(pass), e.expPass);
      end
    end
  end

  task automatic runVector(input int i);
    mode = tbl[i].mode;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    expQ.push_back(tbl[i]);
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k < 12) checkOutput("dut_in_seq", int'(dut_in), k / 3);
      checkOutput("busy_seq", int'(busy), (k < 12) ? 1 : 0);
      checkOutput("done_timing", int'(done), (k == 12) ? 1 : 0);
      applyStimulus((tbl[i].restart != 0) && (k == 3 || k == 7), 1'b0);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0] = '{mode: NAND_G,  expFail: 0,  expErr: 0, expPass: 1, restart: 0};
    tbl[1] = '{mode: AND_G,   expFail: 15, expErr: 4, expPass: 0, restart: 0};
    tbl[2] = '{mode: STUCK_1, expFail: 8,  expErr: 1, expPass: 0, restart: 0};
    tbl[3] = '{mode: NAND_G,  expFail: 0,  expErr: 0, expPass: 1, restart: 1};

    #12;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_pass", int'(pass), 0);
    checkOutput("rst_fail_vec", int'(fail_vec), 0);
    checkOutput("rst_err_count", int'(err_count), 0);
    checkOutput("rst_dut_in", int'(dut_in), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) runVector(i);

    // abort beats start in IDLE
    @(negedge clk);
    applyStimulus(1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("abort_suppresses_start", int'(busy), 0);
    applyStimulus(1'b0, 1'b0);

    // abort while sampling vector 2
    mode = NAND_G;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #1;
      applyStimulus(1'b0, k == 6);
    end
    checkOutput("pre_abort_dut_in", int'(dut_in), 2);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_dut_in", int'(dut_in), 0);
    checkOutput("abort_pass", int'(pass), 0);
    checkOutput("abort_done", int'(done), 0);
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("post_abort_idle", int'(busy), 0);
    end
    runVector(0);

    // asynchronous reset in the middle of an AND run, after vector 0 has failed
    mode = AND_G;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pre_reset_err_count", int'(err_count), 1);
    checkOutput("pre_reset_fail_vec", int'(fail_vec), 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_dut_in", int'(dut_in), 0);
    checkOutput("async_rst_fail_vec", int'(fail_vec), 0);
    checkOutput("async_rst_err_count", int'(err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) begin
      @(posedge clk);
      #1;
      checkOutput("post_reset_done", int'(done), 0);
    end

    // start held high through DONE restarts with no idle cycle
    mode = NAND_G;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    expQ.push_back(tbl[0]);
    for (int k = 0; k <= 25; k++) begin
      @(posedge clk);
      #1;
      if (k == 12) begin
        checkOutput("b2b_done1", int'(done), 1);
        expQ.push_back(tbl[0]);
      end
      if (k == 13) begin
        checkOutput("b2b_restart_busy", int'(busy), 1);
        checkOutput("b2b_restart_done", int'(done), 0);
        checkOutput("b2b_restart_dut_in", int'(dut_in), 0);
        applyStimulus(1'b0, 1'b0);
      end
      if (k == 25) checkOutput("b2b_done2", int'(done), 1);
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Self-checking sequencer that exhaustively exercises one N-input combinational gate (NAND, NOR, XOR, etc.).
- Drives every input combination in order, waits a settle interval, samples the gate output, compares it with a parameterised truth table, and accumulates per-vector failures.
- Sits between a top-level start/status interface and a single gate instance; it is the on-chip replacement for open-loop stimulus benches.

Parameters:
- N_IN, 2, number of gate inputs; number of vectors V = 2**N_IN; legal range 1..4.
- SETTLE, 2, cycles each vector is held before sampling; minimum 1.
- TRUTH, 4'b0111, expected output per vector, width V; bit i = expected y when dut_in = i; default is 2-input NAND.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; accepted only in IDLE or DONE.
- abort  input  1  synchronous abort; wins over start.
- dut_y  input  1  output of the gate under test.
- dut_in  output  N_IN  input vector driven to the gate; dut_in[N_IN-1] is MSB (input a for 2-input).
- busy  output  1  high while WAIT or SAMPLE.
- done  output  1  one-cycle pulse on completion.
- pass  output  1  result of the last completed run; high iff fail_vec == 0.
- fail_vec  output  V  bit i set if vector i mismatched.
- err_count  output  N_IN+1  number of mismatching vectors, 0..V.

Behaviour:
- Reset (async assert, sync release): state=IDLE, dut_in=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0, idx=0, wait_cnt=0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE/DONE with start=1, abort=0 at an edge:
  - idx<=0, dut_in<=0, fail_vec<=0, err_count<=0, pass<=0.
  - wait_cnt<=SETTLE-1, busy<=1, state<=WAIT.
- WAIT:
  - wait_cnt!=0: decrement.
  - wait_cnt==0: state<=SAMPLE.
  - The vector is held SETTLE cycles in WAIT.
- SAMPLE (one cycle), at the edge leaving it:
  - Compare dut_y with TRUTH[idx]; on mismatch set fail_vec[idx] and increment err_count.
  - If idx==V-1: state<=DONE, busy<=0, done<=1, pass<=(final fail_vec==0); the final fail_vec includes this sample's result.
  - Else: idx<=idx+1, dut_in<=idx+1, wait_cnt<=SETTLE-1, state<=WAIT.
- Per-vector period is SETTLE+1 cycles.
  - Total run: V*(SETTLE+1) cycles from the start edge to the edge that enters DONE; done is high the cycle after.
  - Default: 12 cycles.
- DONE:
  - done high exactly one cycle.
  - Next edge: start=1 restarts immediately (as from IDLE); otherwise state<=IDLE.
  - done deasserts in both cases.
- Results persistence: pass, fail_vec and err_count hold until the next accepted start or reset.
  - During a run, fail_vec and err_count show partial results.
- abort=1 at any edge in WAIT/SAMPLE:
  - state<=IDLE, busy<=0, dut_in<=0, pass<=0.
  - No done pulse; fail_vec and err_count keep partial values.
  - abort in IDLE/DONE: no effect except start is suppressed.
- start while busy: ignored; no restart, no counter change.
- dut_y is sampled only in SAMPLE; its value in other states is don't-care (X must not propagate into state).
- No overflow: err_count max V fits N_IN+1 bits. idx wraps only via the restart path, never by increment past V-1.
- rst_n low mid-run: immediate return to reset values, including clearing pass/fail_vec/err_count; no done.

Test Plan:
- Correct NAND model, SETTLE=2, start pulse at cycle 0:
  - dut_in = 00,01,10,11, each held 3 cycles.
  - done pulses once at cycle 12.
  - pass=1, err_count=0, fail_vec=4'b0000.
- AND model substituted (outputs 0,0,0,1): fail_vec=4'b1111, err_count=4, pass=0, done still at cycle 12.
- NAND with output stuck at 1: fail_vec=4'b1000, err_count=1, pass=0.
- start pulsed again at cycles 3 and 7 during a run: ignored; dut_in sequence and done timing identical to the first scenario.
- abort at cycle 7 (idx=2): next cycle state IDLE, busy=0, dut_in=00, no done, pass=0; a fresh start then completes with pass=1.
- rst_n low at cycle 5 for 1 cycle (asynchronous, mid-edge): outputs zero immediately; no done until a new start; back-to-back start held high through DONE restarts with zero idle gap.
